prga: RTL and testbench
=======================

// Module: prga
// PURPOSE
//  ARC4 pseudo-random generation / decrypt engine: en/rdy responder, started by the top-level
//  sequencer once init and ksa have filled S. Reads the KSA-scrambled S memory and a
//  length-prefixed ciphertext memory, continues the i/j swap walk, writes plaintext memory.
//  Same memory-side conventions as init/ksa: addr/wrdata/wren out, rddata in, 1-cycle read.
// PARAMETERS
//  none (S fixed at 256 x 8; messages length-prefixed, max 255 bytes)
// PORTS
//  clk        in   1  system clock (CLOCK_50); all state on rising edge
//  rst        in   1  reset, asynchronous, active-high
//  en         in   1  start request; sampled only while rdy=1
//  rdy        out  1  1 = idle, ready to accept en
//  s_addr     out  8  S memory address
//  s_rddata   in   8  S memory read data (valid cycle after address presented)
//  s_wrdata   out  8  S memory write data
//  s_wren     out  1  S memory write enable
//  ct_addr    out  8  ciphertext memory address (read-only)
//  ct_rddata  in   8  ciphertext read data (1-cycle latency)
//  pt_addr    out  8  plaintext memory address
//  pt_wrdata  out  8  plaintext write data
//  pt_wren    out  1  plaintext write enable
//  pt_bad     out  1  non-printable plaintext flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, rdy=1, s_wren=pt_wren=0, all addr/wrdata=0,
//   i=j=k=0, L=0, pt_bad=0. Reset mid-message abandons it; no further writes.
//  Handshake: en=1 in IDLE accepts; rdy=0 from next cycle until return to IDLE.
//   en while rdy=0 ignored (no queue). en held high in IDLE restarts immediately.
//  Memory: address driven in cycle t -> read data captured in cycle t+1. Writes take effect
//   at the edge ending the cycle wren=1. wren asserted exactly one cycle per write.
//  All index arithmetic 8-bit modulo 256 (i, j, si+sj); k 8-bit counter 1..L.
//  States (one cycle each):
//   IDLE    rdy=1; on en: i=0, j=0, k=1 -> LEN_RD
//   LEN_RD  ct_addr=0 -> LEN_WR
//   LEN_WR  L=ct_rddata; pt_addr=0, pt_wrdata=L, pt_wren=1; L==0 -> IDLE else SI_RD
//   SI_RD   s_addr=i+1, ct_addr=k; i<=i+1 -> SJ_RD
//   SJ_RD   si=s_rddata, c=ct_rddata; s_addr=j+si; j<=j+si -> SWAP_I
//   SWAP_I  sj=s_rddata; s_addr=i, s_wrdata=sj, s_wren=1 -> SWAP_J
//   SWAP_J  s_addr=j, s_wrdata=si, s_wren=1 -> PAD_RD
//   PAD_RD  s_addr=si+sj -> PT_WR
//   PT_WR   pt_addr=k, pt_wrdata=s_rddata^c, pt_wren=1; k==L -> IDLE else k<=k+1, SI_RD
//  i==j: SWAP_I then SWAP_J both hit S[i]; final value si (no net change), as required.
//  Latency: rdy low exactly 2+6*L cycles (2 when L=0). pt[0]=L always written.
//  Outputs not listed for a state are 0 (wren) or hold last value (addr/wrdata).
// CONFIGURATION
//  PRGA_ASCII_CHECK_EN defined: pt_bad cleared on accept; set (sticky) in any PT_WR whose
//   pt_wrdata is outside 0x20..0x7E; valid once rdy returns high; held until next accept.
//  Not defined: pt_bad tied 0; no check logic synthesised. Port list unchanged.
// TESTING
//  S=identity (S[x]=x), ct={01,00}: pt={01,02}; rdy low 8 cycles; S unchanged.
//  S=identity, ct={02,00,00}: pt={02,02,05}; afterwards S[2]=03,S[3]=02; rdy low 14 cycles.
//  ct={00}: pt[0]=00 only, no S writes, rdy low exactly 2 cycles.
//  Pulse en during busy (cycle 4 of test 2): ignored; results and timing identical.
//  Assert rst in SWAP_I of byte 1: rdy=1, s_wren=pt_wren=0 same cycle; fresh en reruns OK.
//  PRGA_ASCII_CHECK_EN, S=identity, ct={01,7D}: pt[1]=7F, pt_bad=1; ct={01,43}: pt_bad=0.

Source files
------------

// File: rtl/prga.sv
// prga: ARC4 PRGA decrypt engine; optional printable-ASCII check under PRGA_ASCII_CHECK_EN
module prga (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren,
  output logic       pt_bad
);
  typedef enum logic [3:0] {IDLE, LEN_RD, LEN_WR, SI_RD, SJ_RD, SWAP_I, SWAP_J, PAD_RD, PT_WR} state_t;
  state_t state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d, l_q, l_d;
  logic [7:0] si_q, si_d, sj_q, sj_d, c_q, c_d;
  logic [7:0] s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d;
  logic [7:0] ct_addr_q, ct_addr_d, pt_addr_q, pt_addr_d, pt_wrdata_q, pt_wrdata_d;
`ifdef PRGA_ASCII_CHECK_EN
  logic pt_bad_q, pt_bad_d;
  assign pt_bad = pt_bad_q;
`else
  assign pt_bad = 1'b0;
`endif
  // Memory ports are driven straight from the next-value logic so reads/writes land in the
  // cycle the state owns them; the _q copies hold address/data between uses.
  assign rdy       = state_q == IDLE;
  assign s_addr    = s_addr_d;
  assign s_wrdata  = s_wrdata_d;
  assign ct_addr   = ct_addr_d;
  assign pt_addr   = pt_addr_d;
  assign pt_wrdata = pt_wrdata_d;
  // Next-state, datapath and memory-port decode for the one-cycle-per-step swap walk
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    l_d         = l_q;
    si_d        = si_q;
    sj_d        = sj_q;
    c_d         = c_q;
    s_addr_d    = s_addr_q;
    s_wrdata_d  = s_wrdata_q;
    ct_addr_d   = ct_addr_q;
    pt_addr_d   = pt_addr_q;
    pt_wrdata_d = pt_wrdata_q;
    s_wren      = 1'b0;
    pt_wren     = 1'b0;
`ifdef PRGA_ASCII_CHECK_EN
    pt_bad_d    = pt_bad_q;
`endif
    case (state_q)
      IDLE: if (en) begin
        state_d = LEN_RD;
        i_d     = 8'd0;
        j_d     = 8'd0;
        k_d     = 8'd1;
`ifdef PRGA_ASCII_CHECK_EN
        pt_bad_d = 1'b0;
`endif
      end
      LEN_RD: begin
        ct_addr_d = 8'd0;
        state_d   = LEN_WR;
      end
      LEN_WR: begin
        l_d         = ct_rddata;
        pt_addr_d   = 8'd0;
        pt_wrdata_d = ct_rddata;
        pt_wren     = 1'b1;
        state_d     = ct_rddata == 8'd0 ? IDLE : SI_RD;
      end
      SI_RD: begin
        s_addr_d  = i_q + 8'd1;
        ct_addr_d = k_q;
        i_d       = i_q + 8'd1;
        state_d   = SJ_RD;
      end
      SJ_RD: begin
        si_d     = s_rddata;
        c_d      = ct_rddata;
        s_addr_d = j_q + s_rddata;
        j_d      = j_q + s_rddata;
        state_d  = SWAP_I;
      end
      SWAP_I: begin
        sj_d       = s_rddata;
        s_addr_d   = i_q;
        s_wrdata_d = s_rddata;
        s_wren     = 1'b1;
        state_d    = SWAP_J;
      end
      SWAP_J: begin
        s_addr_d   = j_q;
        s_wrdata_d = si_q;
        s_wren     = 1'b1;
        state_d    = PAD_RD;
      end
      PAD_RD: begin
        s_addr_d = si_q + sj_q;
        state_d  = PT_WR;
      end
      PT_WR: begin
        pt_addr_d   = k_q;
        pt_wrdata_d = s_rddata ^ c_q;
        pt_wren     = 1'b1;
`ifdef PRGA_ASCII_CHECK_EN
        if (pt_wrdata_d < 8'h20 || pt_wrdata_d > 8'h7e) pt_bad_d = 1'b1;
`endif
        state_d = k_q == l_q ? IDLE : SI_RD;
        k_d     = k_q == l_q ? k_q : k_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and held port values; reset abandons any message in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      k_q         <= 8'd0;
      l_q         <= 8'd0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
      c_q         <= 8'd0;
      s_addr_q    <= 8'd0;
      s_wrdata_q  <= 8'd0;
      ct_addr_q   <= 8'd0;
      pt_addr_q   <= 8'd0;
      pt_wrdata_q <= 8'd0;
`ifdef PRGA_ASCII_CHECK_EN
      pt_bad_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      l_q         <= l_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      c_q         <= c_d;
      s_addr_q    <= s_addr_d;
      s_wrdata_q  <= s_wrdata_d;
      ct_addr_q   <= ct_addr_d;
      pt_addr_q   <= pt_addr_d;
      pt_wrdata_q <= pt_wrdata_d;
`ifdef PRGA_ASCII_CHECK_EN
      pt_bad_q    <= pt_bad_d;
`endif
    end
  end
endmodule

// File: tb/tb_prga.sv
// tb_prga: randomized bench for prga against an RC4 reference model with memory models
module tb_prga;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0;
  logic rdy, s_wren, pt_wren, pt_bad;
  logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
  logic [7:0] s_mem [256], s_init [256], ct_mem [256], pt_mem [256], exp_s [256], exp_pt [256];
  int s_wr_cnt, exp_l;
  logic exp_bad;
  logic lit_on = 1'b0, lit_bad = 1'b0;
  int lit_n = 0;
  logic [7:0] lit_pt [3], lit_si [2], lit_sv [2];
  logic chk_reset = 1'b1, abort = 1'b0;
  int run_id = 0, done_id = 0, checks = 0, errors = 0;

  always #5 clk = ~clk;

  prga dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren), .pt_bad(pt_bad)
  );

  // synchronous memories with one-cycle read latency; load installs a fresh S image
  always @(posedge clk) begin
    if (load) begin
      s_mem <= s_init;
      for (int x = 0; x < 256; x++) pt_mem[x] <= 8'hee;
      s_wr_cnt <= 0;
    end else begin
      if (s_wren) begin
        s_mem[s_addr] <= s_wrdata;
        s_wr_cnt <= s_wr_cnt + 1;
      end
      if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    end
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // plain RC4 keystream walk over the loaded S image
  task automatic model(input int l);
    logic [7:0] i, j, t, p;
    exp_s = s_init;
    i = 8'd0;
    j = 8'd0;
    exp_pt[0] = 8'(l);
    exp_bad = 1'b0;
    for (int k = 1; k <= l; k++) begin
      i = i + 8'd1;
      j = j + exp_s[i];
      t = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
      p = exp_s[8'(exp_s[i] + exp_s[j])] ^ ct_mem[k];
      exp_pt[k] = p;
`ifdef PRGA_ASCII_CHECK_EN
      if (p < 8'h20 || p > 8'h7e) exp_bad = 1'b1;
`endif
    end
    exp_l = l;
  endtask

  // single compare process: per-cycle write checks, end-of-message checks when rdy returns
  initial begin
    int busy, wr_idx, bad_cnt;
    busy = 0;
    wr_idx = 0;
    forever begin
      @(negedge clk);
      if (chk_reset)
        check("reset_outputs", 64'({rdy, s_wren, pt_wren, s_addr, ct_addr, pt_addr, s_wrdata, pt_wrdata, pt_bad}), 64'(1) << 43);
      if (rdy) check("idle_wren", 64'({s_wren, pt_wren}), 64'(0));
      if (!rdy) begin
        busy++;
        if (pt_wren) begin
          check("pt_addr", 64'(pt_addr), 64'(wr_idx));
          check("pt_data", 64'(pt_wrdata), 64'(exp_pt[wr_idx]));
          if (lit_on && wr_idx < lit_n) check("pt_literal", 64'(pt_wrdata), 64'(lit_pt[wr_idx]));
          wr_idx++;
        end
      end else if (busy > 0) begin
        if (!abort) begin
          check("busy_cycles", 64'(busy), 64'(exp_l * 6 + 2));
          check("pt_writes", 64'(wr_idx), 64'(exp_l + 1));
          check("s_writes", 64'(s_wr_cnt), 64'(exp_l * 2));
          bad_cnt = 0;
          for (int x = 0; x < 256; x++) if (s_mem[x] !== exp_s[x]) bad_cnt++;
          for (int x = 0; x <= exp_l; x++) if (pt_mem[x] !== exp_pt[x]) bad_cnt++;
          check("mem_image", 64'(bad_cnt), 64'(0));
          check("pt_bad", 64'(pt_bad), 64'(exp_bad));
          if (lit_on) begin
            for (int q = 0; q < 2; q++) check("s_literal", 64'(s_mem[lit_si[q]]), 64'(lit_sv[q]));
            check("pt_bad_literal", 64'(pt_bad), 64'(lit_bad));
          end
          done_id = run_id;
        end
        busy = 0;
        wr_idx = 0;
      end
    end
  end

  task automatic run(input int l, input bit pulse);
    model(l);
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    run_id++;
    en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    if (pulse) begin
      repeat (3) @(posedge clk);
      #1 en = 1'b1;
      @(posedge clk); #1 en = 1'b0;
    end
    for (int c = 0; c < 3000 && done_id != run_id; c++) @(posedge clk);
    if (done_id != run_id) begin
      $display("FAIL timeout: run %0d got no return to rdy, want %0d busy cycles", run_id, l * 6 + 2);
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
    end
  endtask

  task automatic set_ct(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    ct_mem[0] = a;
    ct_mem[1] = b;
    ct_mem[2] = c;
  endtask

  initial begin
    int l;
    logic [7:0] t;
    for (int x = 0; x < 256; x++) begin
      s_init[x] = 8'(x);
      ct_mem[x] = 8'h00;
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0; chk_reset = 1'b0;
    lit_on = 1'b1;
    set_ct(8'h01, 8'h00, 8'h00);
    lit_n = 2; lit_pt = '{8'h01, 8'h02, 8'h00}; lit_si = '{8'h01, 8'h02}; lit_sv = '{8'h01, 8'h02};
    run(1, 1'b0);
    set_ct(8'h02, 8'h00, 8'h00);
    lit_n = 3; lit_pt = '{8'h02, 8'h02, 8'h05}; lit_si = '{8'h02, 8'h03}; lit_sv = '{8'h03, 8'h02};
    run(2, 1'b0);
    run(2, 1'b1);
    set_ct(8'h00, 8'h00, 8'h00);
    lit_n = 1; lit_pt = '{8'h00, 8'h00, 8'h00}; lit_si = '{8'h00, 8'h01}; lit_sv = '{8'h00, 8'h01};
    run(0, 1'b0);
    set_ct(8'h01, 8'h7d, 8'h00);
    lit_n = 2; lit_pt = '{8'h01, 8'h7f, 8'h00}; lit_si = '{8'h01, 8'h02}; lit_sv = '{8'h01, 8'h02};
`ifdef PRGA_ASCII_CHECK_EN
    lit_bad = 1'b1;
`else
    lit_bad = 1'b0;
`endif
    run(1, 1'b0);
    set_ct(8'h01, 8'h43, 8'h00);
    lit_pt = '{8'h01, 8'h41, 8'h00}; lit_bad = 1'b0;
    run(1, 1'b0);
    lit_on = 1'b0;
    set_ct(8'h02, 8'h11, 8'h22);
    model(2);
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0; en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    repeat (4) @(posedge clk);
    #2 abort = 1'b1; chk_reset = 1'b1; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; chk_reset = 1'b0;
    @(posedge clk); #1 abort = 1'b0;
    lit_on = 1'b1;
    set_ct(8'h02, 8'h00, 8'h00);
    lit_n = 3; lit_pt = '{8'h02, 8'h02, 8'h05}; lit_si = '{8'h02, 8'h03}; lit_sv = '{8'h03, 8'h02};
    run(2, 1'b0);
    lit_on = 1'b0;
    for (int r = 0; r < 21; r++) begin
      for (int x = 255; x > 0; x--) begin
        l = $urandom_range(0, x);
        t = s_init[x];
        s_init[x] = s_init[l];
        s_init[l] = t;
      end
      l = r == 20 ? 255 : (r % 7 == 3 ? 0 : $urandom_range(1, 40));
      ct_mem[0] = 8'(l);
      for (int x = 1; x < 256; x++) ct_mem[x] = 8'($urandom_range(0, 255));
      run(l, r % 5 == 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
